// File: rtl/lif_neuron_scheduler_if.sv
// Host-side control bundle for the LIF neuron scheduler:
// config byte stream, pass control and spike result.
interface lif_neuron_scheduler_if #(
    parameter int N_NEURONS = 4
) ();
    logic                 cfg_valid;
    logic                 cfg_ready;
    logic [1:0]           cfg_sel;
    logic [7:0]           cfg_data;
    logic                 clear_state;
    logic                 start;
    logic                 busy;
    logic                 done;
    logic [N_NEURONS-1:0] spike_vec;

    modport master (
        output cfg_valid, cfg_sel, cfg_data, clear_state, start,
        input  cfg_ready, busy, done, spike_vec
    );

    modport slave (
        input  cfg_valid, cfg_sel, cfg_data, clear_state, start,
        output cfg_ready, busy, done, spike_vec
    );
endinterface

// File: rtl/lif_neuron_scheduler.sv
// Time-multiplexes one external LIF datapath over N_NEURONS virtual neurons,
// holding their weights, potentials and spike state plus a shared input vector.
module lif_neuron_scheduler #(
    parameter  int N_STAGES  = 4,
    parameter  int N_NEURONS = 4,
    localparam int INPUTS    = 2 ** N_STAGES,
    localparam int W         = N_STAGES + 2,
    localparam int BPN       = INPUTS / 8,
    localparam int NB        = N_NEURONS * BPN,
    localparam int IW        = $clog2(N_NEURONS),
    localparam int PW        = $clog2(NB)
) (
    input  logic                  clk,
    input  logic                  reset,
    lif_neuron_scheduler_if.slave ctl,
    output logic [INPUTS-1:0]     dp_w,
    output logic [INPUTS-1:0]     dp_x,
    output logic [W-1:0]          dp_prev_u,
    output logic                  dp_was_spike,
    output logic [W-1:0]          dp_minus_teta,
    output logic [2:0]            dp_shift,
    input  logic [W-1:0]          dp_u_out,
    input  logic                  dp_spike
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                state_q, state_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [PW-1:0]         wp_q, wp_d;
    logic [INPUTS-1:0]     w_q [N_NEURONS];
    logic [INPUTS-1:0]     w_d [N_NEURONS];
    logic [INPUTS-1:0]     x_q, x_d;
    logic [W-1:0]          u_q [N_NEURONS];
    logic [W-1:0]          u_d [N_NEURONS];
    logic [N_NEURONS-1:0]  ws_q, ws_d;
    logic [N_NEURONS-1:0]  spk_q, spk_d;
    logic [W-1:0]          mt_q, mt_d;
    logic [2:0]            sh_q, sh_d;
    logic [IW-1:0]         sel;

    assign ctl.cfg_ready = (state_q == IDLE) && !ctl.start;
    assign ctl.busy      = (state_q != IDLE);
    assign ctl.done      = (state_q == DONE);
    assign ctl.spike_vec = spk_q;

    // Outside RUN the datapath sees neuron 0; its result is not captured there.
    assign sel           = (state_q == RUN) ? idx_q : '0;
    assign dp_w          = w_q[sel];
    assign dp_x          = x_q;
    assign dp_prev_u     = u_q[sel];
    assign dp_was_spike  = ws_q[sel];
    assign dp_minus_teta = mt_q;
    assign dp_shift      = sh_q;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        wp_d    = wp_q;
        w_d     = w_q;
        x_d     = x_q;
        u_d     = u_q;
        ws_d    = ws_q;
        spk_d   = spk_q;
        mt_d    = mt_q;
        sh_d    = sh_q;
        unique case (state_q)
            IDLE: begin
                if (ctl.start) begin
                    state_d = RUN;
                    idx_d   = '0;
                end else begin
                    if (ctl.cfg_valid) begin
                        unique case (ctl.cfg_sel)
                            2'b00: x_d = INPUTS'({x_q, ctl.cfg_data});
                            2'b01: begin
                                for (int n = 0; n < N_NEURONS; n++)
                                    for (int b = 0; b < BPN; b++)
                                        if (wp_q == PW'(n * BPN + b))
                                            w_d[n][8*b +: 8] = ctl.cfg_data;
                                wp_d = (wp_q == PW'(NB - 1)) ? '0 : wp_q + PW'(1);
                            end
                            2'b10: mt_d = ctl.cfg_data[W-1:0];
                            2'b11: sh_d = ctl.cfg_data[2:0];
                            default: ;
                        endcase
                    end
                    if (ctl.clear_state) begin
                        for (int n = 0; n < N_NEURONS; n++)
                            u_d[n] = '0;
                        ws_d = '0;
                        wp_d = '0;
                    end
                end
            end
            RUN: begin
                u_d[idx_q]   = dp_u_out;
                ws_d[idx_q]  = dp_spike;
                spk_d[idx_q] = dp_spike;
                if (idx_q == IW'(N_NEURONS - 1))
                    state_d = DONE;
                else
                    idx_d = idx_q + IW'(1);
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            wp_q    <= '0;
            x_q     <= '0;
            ws_q    <= '0;
            spk_q   <= '0;
            mt_q    <= W'(-5);
            sh_q    <= '0;
            for (int n = 0; n < N_NEURONS; n++) begin
                w_q[n] <= '1;
                u_q[n] <= '0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            wp_q    <= wp_d;
            w_q     <= w_d;
            x_q     <= x_d;
            u_q     <= u_d;
            ws_q    <= ws_d;
            spk_q   <= spk_d;
            mt_q    <= mt_d;
            sh_q    <= sh_d;
        end
    end

endmodule

// File: tb/tb_lif_neuron_scheduler.sv
// Scoreboarded bench for lif_neuron_scheduler with a behavioural LIF
// datapath model closing the dp_* loop.
module tb_lif_neuron_scheduler;
    localparam int NS = 4;
    localparam int N  = 4;
    localparam int IN = 16;
    localparam int W  = 6;

    logic          clk = 1'b0;
    logic          reset;
    logic [IN-1:0] dp_w, dp_x;
    logic [W-1:0]  dp_prev_u, dp_minus_teta, dp_u_out;
    logic          dp_was_spike, dp_spike;
    logic [2:0]    dp_shift;

    lif_neuron_scheduler_if #(.N_NEURONS(N)) bus ();

    lif_neuron_scheduler #(.N_STAGES(NS), .N_NEURONS(N)) dut (
        .clk           (clk),
        .reset         (reset),
        .ctl           (bus),
        .dp_w          (dp_w),
        .dp_x          (dp_x),
        .dp_prev_u     (dp_prev_u),
        .dp_was_spike  (dp_was_spike),
        .dp_minus_teta (dp_minus_teta),
        .dp_shift      (dp_shift),
        .dp_u_out      (dp_u_out),
        .dp_spike      (dp_spike)
    );

    always #5 clk = ~clk;

    // Leak (reset to 0 after a spike, else arithmetic shift) plus popcount input.
    function automatic logic [W-1:0] lif_u(logic [IN-1:0] w, logic [IN-1:0] x,
                                           logic [W-1:0] pu, logic ws, logic [2:0] sh);
        logic signed [W-1:0] lk;
        int pc;
        lk = ws ? '0 : ($signed(pu) >>> sh);
        pc = $countones(w & x);
        return W'(lk) + W'(pc);
    endfunction

    function automatic logic lif_s(logic [W-1:0] u, logic [W-1:0] mt);
        return (int'($signed(u)) + int'($signed(mt))) >= 0;
    endfunction

    assign dp_u_out = lif_u(dp_w, dp_x, dp_prev_u, dp_was_spike, dp_shift);
    assign dp_spike = lif_s(dp_u_out, dp_minus_teta);

    logic [IN-1:0] mw [N];
    logic [IN-1:0] mx;
    logic [W-1:0]  mu [N];
    logic [N-1:0]  mws, mspk;
    logic [W-1:0]  mmt;
    logic [2:0]    msh;
    int            mwp;
    int            checks = 0;
    int            errors = 0;
    logic [N-1:0]  sb_spk [$];
    logic [W-1:0]  sb_u0 [$];

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            mw[i] = '1;
            mu[i] = '0;
        end
        mx   = '0;
        mws  = '0;
        mspk = '0;
        mmt  = 6'h3B;
        msh  = '0;
        mwp  = 0;
    endtask

    task automatic cfg_write(input logic [1:0] s, input logic [7:0] d);
        @(negedge clk);
        bus.cfg_valid = 1'b1;
        bus.cfg_sel   = s;
        bus.cfg_data  = d;
        #1;
        checks++;
        if (bus.cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL cfg_ready_idle got %b want 1", bus.cfg_ready);
        end
        @(negedge clk);
        bus.cfg_valid = 1'b0;
        case (s)
            2'b00: mx = {mx[7:0], d};
            2'b01: begin
                mw[mwp/2][8*(mwp%2) +: 8] = d;
                mwp = (mwp + 1) % (2 * N);
            end
            2'b10: mmt = d[W-1:0];
            default: msh = d[2:0];
        endcase
    endtask

    task automatic run_pass(input bit hold);
        logic [W-1:0] nu [N];
        logic [N-1:0] nws, old_spk, e_spk, got_spk;
        logic [W-1:0] e_u0;
        for (int i = 0; i < N; i++) begin
            nu[i]  = lif_u(mw[i], mx, mu[i], mws[i], msh);
            nws[i] = lif_s(nu[i], mmt);
        end
        sb_spk.push_back(nws);
        sb_u0.push_back(nu[0]);
        old_spk = mspk;
        @(negedge clk);
        bus.start = 1'b1;
        if (hold) begin
            bus.cfg_valid   = 1'b1;
            bus.cfg_sel     = 2'b10;
            bus.cfg_data    = 8'h3F;
            bus.clear_state = 1'b1;
        end
        #1;
        checks++;
        if (bus.cfg_ready !== 1'b0) begin
            errors++;
            $display("FAIL cfg_ready_start got %b want 0", bus.cfg_ready);
        end
        @(negedge clk);
        bus.start       = 1'b0;
        bus.clear_state = 1'b0;
        for (int i = 0; i < N; i++) begin
            checks++;
            if ({bus.busy, bus.done} !== 2'b10) begin
                errors++;
                $display("FAIL run_flags n%0d got %b want 10", i, {bus.busy, bus.done});
            end
            checks++;
            if ({dp_w, dp_x, dp_prev_u, dp_was_spike, dp_minus_teta, dp_shift} !==
                {mw[i], mx, mu[i], mws[i], mmt, msh}) begin
                errors++;
                $display("FAIL dp_n%0d got %h want %h", i,
                    {dp_w, dp_x, dp_prev_u, dp_was_spike, dp_minus_teta, dp_shift},
                    {mw[i], mx, mu[i], mws[i], mmt, msh});
            end
            for (int j = 0; j < N; j++)
                e_spk[j] = (j < i) ? nws[j] : old_spk[j];
            checks++;
            if (bus.spike_vec !== e_spk) begin
                errors++;
                $display("FAIL run_spike_vec n%0d got %b want %b", i, bus.spike_vec, e_spk);
            end
            if (hold) begin
                checks++;
                if (bus.cfg_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL cfg_ready_busy got %b want 0", bus.cfg_ready);
                end
            end
            @(negedge clk);
        end
        checks++;
        if ({bus.busy, bus.done} !== 2'b11) begin
            errors++;
            $display("FAIL done_pulse got %b want 11", {bus.busy, bus.done});
        end
        checks++;
        if (sb_spk.size() == 0) begin
            errors++;
            $display("FAIL sb_empty got 0 entries want 1");
        end else begin
            e_spk   = sb_spk.pop_front();
            got_spk = bus.spike_vec;
            if (got_spk !== e_spk) begin
                errors++;
                $display("FAIL spike_vec got %b want %b", got_spk, e_spk);
            end
        end
        for (int i = 0; i < N; i++)
            mu[i] = nu[i];
        mws  = nws;
        mspk = nws;
        @(negedge clk);
        if (hold)
            bus.cfg_valid = 1'b0;
        checks++;
        if ({bus.busy, bus.done} !== 2'b00) begin
            errors++;
            $display("FAIL idle_flags got %b want 00", {bus.busy, bus.done});
        end
        e_u0 = sb_u0.pop_front();
        checks++;
        if ({dp_prev_u, dp_was_spike} !== {e_u0, mws[0]}) begin
            errors++;
            $display("FAIL idle_n0_state got %h want %h", {dp_prev_u, dp_was_spike}, {e_u0, mws[0]});
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.cfg_valid = 1'b0;
        bus.cfg_sel = 2'b00;
        bus.cfg_data = 8'h00;
        bus.clear_state = 1'b0;
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({bus.busy, bus.done, bus.spike_vec, bus.cfg_ready} !== 7'b0000001) begin
            errors++;
            $display("FAIL reset_ctl got %b want 0000001", {bus.busy, bus.done, bus.spike_vec, bus.cfg_ready});
        end
        checks++;
        if ({dp_w, dp_x, dp_prev_u, dp_was_spike, dp_minus_teta, dp_shift} !==
            {16'hFFFF, 16'h0000, 6'd0, 1'b0, 6'h3B, 3'd0}) begin
            errors++;
            $display("FAIL reset_dp got %h want %h",
                {dp_w, dp_x, dp_prev_u, dp_was_spike, dp_minus_teta, dp_shift},
                {16'hFFFF, 16'h0000, 6'd0, 1'b0, 6'h3B, 3'd0});
        end
    endtask

    task automatic test_basic();
        cfg_write(2'b00, 8'hFF);
        cfg_write(2'b00, 8'hFF);
        run_pass(1'b0);
        checks++;
        if (bus.spike_vec !== 4'b1111) begin
            errors++;
            $display("FAIL basic_spikes got %b want 1111", bus.spike_vec);
        end
    endtask

    task automatic test_weights();
        cfg_write(2'b01, 8'h00);
        cfg_write(2'b01, 8'h00);
        for (int i = 0; i < 6; i++)
            cfg_write(2'b01, 8'hFF);
        cfg_write(2'b00, 8'hFF);
        cfg_write(2'b00, 8'hFF);
        run_pass(1'b0);
        checks++;
        if ({bus.spike_vec, dp_prev_u} !== {4'b1110, 6'd0}) begin
            errors++;
            $display("FAIL weights_result got %h want %h", {bus.spike_vec, dp_prev_u}, {4'b1110, 6'd0});
        end
    endtask

    task automatic test_wrap();
        logic [7:0] b;
        for (int i = 0; i < 9; i++) begin
            b = 8'(8'h11 * (i + 1));
            cfg_write(2'b01, b);
        end
        checks++;
        if (dp_w !== 16'h2299) begin
            errors++;
            $display("FAIL wrap_n0 got %h want 2299", dp_w);
        end
        run_pass(1'b0);
    endtask

    task automatic test_collide();
        run_pass(1'b1);
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        bus.start = 1'b1;
        repeat (3) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({bus.busy, bus.done, bus.spike_vec} !== 6'b0) begin
            errors++;
            $display("FAIL reset_mid_ctl got %b want 000000", {bus.busy, bus.done, bus.spike_vec});
        end
        checks++;
        if ({dp_w, dp_prev_u, dp_was_spike} !== {16'hFFFF, 6'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset_mid_dp got %h want %h", {dp_w, dp_prev_u, dp_was_spike}, {16'hFFFF, 6'd0, 1'b0});
        end
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if ({bus.busy, bus.done} !== 2'b00) begin
                errors++;
                $display("FAIL reset_mid_quiet c%0d got %b want 00", i, {bus.busy, bus.done});
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] wb [8];
        wb = '{8'hA5, 8'h5A, 8'hF0, 8'h0F, 8'h3C, 8'hC3, 8'hFF, 8'h01};
        cfg_write(2'b11, 8'h01);
        cfg_write(2'b10, 8'h2C);
        for (int i = 0; i < 8; i++)
            cfg_write(2'b01, wb[i]);
        cfg_write(2'b00, 8'hB7);
        cfg_write(2'b00, 8'h6E);
        run_pass(1'b0);
        run_pass(1'b0);
        @(negedge clk);
        bus.clear_state = 1'b1;
        @(negedge clk);
        bus.clear_state = 1'b0;
        for (int i = 0; i < N; i++)
            mu[i] = '0;
        mws = '0;
        mwp = 0;
        checks++;
        if ({dp_prev_u, dp_was_spike} !== 7'd0) begin
            errors++;
            $display("FAIL clear_n0 got %h want 00", {dp_prev_u, dp_was_spike});
        end
        cfg_write(2'b01, 8'hE7);
        checks++;
        if (dp_w[7:0] !== 8'hE7) begin
            errors++;
            $display("FAIL clear_wp got %h want e7", dp_w[7:0]);
        end
        run_pass(1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_weights();
        test_wrap();
        test_collide();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
